parking_spot_allocator: RTL and testbench
=========================================

Name: parking_spot_allocator

Overview:
- Upstream stage of the capacity counter. Owns the 8-bit spot-occupancy register and drives it as `capacity[7:0]`, which feeds the counter's `new_capacity` input. Bit i = 1 means spot i is occupied.
- Serves entry-gate requests by allocating the lowest free spot and opening the gate for a fixed time.
- Serves exit events by releasing the named spot. Flags illegal exits and entries refused because the lot is full.

Parameters:
- N_SPOTS, 8, number of spots and width of `capacity`. Fixed at 8 to match the downstream counter.
- ID_W, 3, width of spot indices; equals clog2(N_SPOTS).
- GATE_CYCLES, 4, number of cycles `gate_open` stays high per grant; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- entry_req  input  1  car waiting at entry gate (level).
- exit_req  input  1  single-cycle pulse: car left spot `exit_spot`.
- exit_spot  input  ID_W  spot being vacated; valid when `exit_req`=1.
- entry_grant  output  1  1-cycle pulse: spot allocated.
- entry_spot  output  ID_W  allocated spot index; holds its value until the next grant.
- entry_deny  output  1  1-cycle pulse: request refused, lot full.
- exit_err  output  1  1-cycle pulse: `exit_req` named an empty spot.
- gate_open  output  1  entry barrier open.
- capacity  output  N_SPOTS  occupancy vector; feeds the capacity counter.
- full  output  1  all spots occupied; combinational AND of `capacity`.

Behaviour:
- Reset (synchronous, active-high): takes effect on the clk edge where `rst`=1. Priority over all other inputs.
  - `capacity` = 0, `entry_spot` = 0, and `entry_grant`, `entry_deny`, `exit_err`, `gate_open` = 0.
  - FSM goes to IDLE; gate timer = 0.
  - Reset during OPEN closes the gate on that edge and discards the allocation.
- All outputs except `full` are registered.
- FSM has two states, IDLE and OPEN.
  - IDLE with `entry_req`=1 and `full`=0: on the edge,
    - set `capacity[k]`, where k is the lowest-index 0 bit of the pre-edge `capacity`;
    - `entry_spot` <= k, `entry_grant` <= 1, `gate_open` <= 1;
    - timer <= GATE_CYCLES-1; state <= OPEN.
    - Latency: request sampled in cycle t, grant visible in cycle t+1.
  - IDLE with `entry_req`=1 and `full`=1: `entry_deny` <= 1 for one cycle; state stays IDLE; `capacity` unchanged for entry. While `entry_req` stays high and the lot stays full, deny re-pulses every cycle.
  - OPEN: `gate_open` stays 1. If timer=0, then `gate_open` <= 0 and state <= IDLE. Otherwise timer decrements.
    - `gate_open` is high for exactly GATE_CYCLES cycles (t+1 .. t+GATE_CYCLES).
    - `entry_req` is ignored in OPEN: no grant and no deny. A level still held is served on the first IDLE cycle (t+GATE_CYCLES+1).
- Exit handling is independent of FSM state and is evaluated every cycle.
  - `exit_req`=1 and `capacity[exit_spot]`=1: clear that bit on the edge.
  - `exit_req`=1 and `capacity[exit_spot]`=0: `exit_err` <= 1 for one cycle; `capacity` unchanged.
- Entry and exit on the same edge:
  - Allocation and the `full` check both use the pre-edge `capacity`.
  - Both updates apply together: next = (cur | entry_set) & ~exit_clr.
  - A spot freed on this edge is not reusable until the next cycle. So a full lot plus a same-cycle exit still produces a deny.
  - Allocation never collides with a legal exit, because a legal exit names an occupied bit.
- No wrap-around or counting happens here; the occupancy count is the downstream counter's job.

Test Plan:
- Reset, then `entry_req` held high for 1 cycle -> `entry_grant` pulse, `entry_spot`=0, `capacity`=8'b00000001, `gate_open` high for exactly 4 cycles, then back to IDLE.
- `entry_req` held high continuously from reset -> grants every 5 cycles, with `entry_spot` = 0,1,2,...,7. After the 8th grant, `capacity`=8'hFF and `full`=1; the next IDLE cycle gives `entry_deny` pulses and no grant.
- With `capacity`=8'hFF, pulse `exit_req` with `exit_spot`=5 -> `capacity`=8'b11011111. A following `entry_req` -> `entry_spot`=5 and `capacity`=8'hFF.
- With `capacity`=8'hFF, assert `entry_req` and an exit of spot 2 in the same IDLE cycle -> `entry_deny`=1 and `capacity`=8'b11111011. Next cycle -> grant with `entry_spot`=2.
- With `capacity`=8'b00000011, pulse `exit_req` with `exit_spot`=6 -> `exit_err` pulse for 1 cycle; `capacity` unchanged at 8'b00000011.
- Assert `rst` during the 2nd cycle of `gate_open` with `capacity`=8'b00000111 -> next cycle `capacity`=0, `gate_open`=0, state IDLE, and all pulse outputs 0.

Source files
------------

// File: rtl/parking_spot_allocator.sv
// Entry/exit front end of the parking capacity counter: owns the occupancy
// vector, hands out the lowest free spot and times the entry barrier.
module parking_spot_allocator #(
    parameter int N_SPOTS     = 8,
    parameter int ID_W        = 3,
    parameter int GATE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               entry_req,
    input  logic               exit_req,
    input  logic [ID_W-1:0]    exit_spot,
    output logic               entry_grant,
    output logic [ID_W-1:0]    entry_spot,
    output logic               entry_deny,
    output logic               exit_err,
    output logic               gate_open,
    output logic [N_SPOTS-1:0] capacity,
    output logic               full
);

    localparam int TIMER_W = 4;

    typedef enum logic {IDLE, OPEN} state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [N_SPOTS-1:0]   cap_q, cap_d;
    logic [ID_W-1:0]      spot_q, spot_d;
    logic                 grant_q, grant_d;
    logic                 deny_q, deny_d;
    logic                 err_q, err_d;
    logic                 gate_q, gate_d;

    logic [N_SPOTS-1:0]   entry_set;
    logic [N_SPOTS-1:0]   exit_clr;
    logic [ID_W-1:0]      free_idx;

    assign full = &cap_q;

    // Scan from the top so the last hit wins: lowest-index free spot.
    always_comb begin
        free_idx = '0;
        for (int i = N_SPOTS-1; i >= 0; i--) begin
            if (!cap_q[i]) free_idx = ID_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        spot_d    = spot_q;
        gate_d    = gate_q;
        grant_d   = 1'b0;
        deny_d    = 1'b0;
        err_d     = 1'b0;
        entry_set = '0;
        exit_clr  = '0;

        case (state_q)
            IDLE: begin
                if (entry_req && !full) begin
                    entry_set[free_idx] = 1'b1;
                    spot_d  = free_idx;
                    grant_d = 1'b1;
                    gate_d  = 1'b1;
                    timer_d = TIMER_W'(GATE_CYCLES-1);
                    state_d = OPEN;
                end else if (entry_req) begin
                    deny_d = 1'b1;
                end
            end
            OPEN: begin
                if (timer_q == '0) begin
                    gate_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (exit_req) begin
            if (cap_q[exit_spot]) exit_clr[exit_spot] = 1'b1;
            else                  err_d = 1'b1;
        end

        // A spot freed this edge only becomes allocatable next cycle.
        cap_d = (cap_q | entry_set) & ~exit_clr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            cap_q   <= '0;
            spot_q  <= '0;
            grant_q <= 1'b0;
            deny_q  <= 1'b0;
            err_q   <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cap_q   <= cap_d;
            spot_q  <= spot_d;
            grant_q <= grant_d;
            deny_q  <= deny_d;
            err_q   <= err_d;
            gate_q  <= gate_d;
        end
    end

    assign entry_grant = grant_q;
    assign entry_spot  = spot_q;
    assign entry_deny  = deny_q;
    assign exit_err    = err_q;
    assign gate_open   = gate_q;
    assign capacity    = cap_q;

endmodule

// File: tb/tb_parking_spot_allocator.sv
// Scoreboard bench for parking_spot_allocator: each scenario queues the
// expected output vector per cycle and compares as the DUT advances.
module tb_parking_spot_allocator;

    logic       clk;
    logic       rst;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_spot;
    logic       entry_grant;
    logic [2:0] entry_spot;
    logic       entry_deny;
    logic       exit_err;
    logic       gate_open;
    logic [7:0] capacity;
    logic       full;

    logic [15:0] obs;
    logic [15:0] e;
    logic [15:0] sb[$];
    int          n_chk;
    int          n_fail;

    parking_spot_allocator #(.N_SPOTS(8), .ID_W(3), .GATE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .entry_req(entry_req), .exit_req(exit_req), .exit_spot(exit_spot),
        .entry_grant(entry_grant), .entry_spot(entry_spot),
        .entry_deny(entry_deny), .exit_err(exit_err),
        .gate_open(gate_open), .capacity(capacity), .full(full)
    );

    // {grant, spot, deny, err, gate, capacity, full}
    assign obs = {entry_grant, entry_spot, entry_deny, exit_err, gate_open, capacity, full};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ex(input logic g, input logic [2:0] s, input logic d,
                                       input logic er, input logic go, input logic [7:0] c);
        return {g, s, d, er, go, c, &c};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_spot = 3'd0;
        sb.push_back(ex(0, 0, 0, 0, 0, 8'h00));
        cyc();
        rst = 1'b0;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL reset: got %b want %b", obs, e);
        end
    endtask

    task automatic test_single_grant();
        entry_req = 1'b1;
        sb.push_back(ex(1, 0, 0, 0, 1, 8'h01));
        cyc();
        entry_req = 1'b0;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL single_grant: got %b want %b", obs, e);
        end
        for (int i = 0; i < 3; i++) sb.push_back(ex(0, 0, 0, 0, 1, 8'h01));
        sb.push_back(ex(0, 0, 0, 0, 0, 8'h01));
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL single_gate: got %b want %b", obs, e);
            end
        end
    endtask

    task automatic test_fill();
        logic [7:0] c;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_chk++;
        if (capacity !== 8'h00) begin
            n_fail++;
            $display("FAIL fill_reset: got %h want 00", capacity);
        end
        entry_req = 1'b1;
        c = 8'h00;
        for (int g = 0; g < 8; g++) begin
            c[g] = 1'b1;
            sb.push_back(ex(1, 3'(g), 0, 0, 1, c));
            for (int i = 0; i < 3; i++) sb.push_back(ex(0, 3'(g), 0, 0, 1, c));
            sb.push_back(ex(0, 3'(g), 0, 0, 0, c));
        end
        sb.push_back(ex(0, 7, 1, 0, 0, 8'hFF));
        sb.push_back(ex(0, 7, 1, 0, 0, 8'hFF));
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL fill: got %b want %b", obs, e);
            end
        end
        entry_req = 1'b0;
        sb.push_back(ex(0, 7, 0, 0, 0, 8'hFF));
        cyc();
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL deny_stop: got %b want %b", obs, e);
        end
    endtask

    task automatic test_exit_refill();
        exit_req = 1'b1; exit_spot = 3'd5;
        sb.push_back(ex(0, 7, 0, 0, 0, 8'hDF));
        cyc();
        exit_req = 1'b0;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL exit5: got %b want %b", obs, e);
        end
        entry_req = 1'b1;
        sb.push_back(ex(1, 5, 0, 0, 1, 8'hFF));
        cyc();
        entry_req = 1'b0;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL refill5: got %b want %b", obs, e);
        end
        for (int i = 0; i < 3; i++) sb.push_back(ex(0, 5, 0, 0, 1, 8'hFF));
        sb.push_back(ex(0, 5, 0, 0, 0, 8'hFF));
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL refill_gate: got %b want %b", obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        // Full lot, entry and exit on the same edge: deny now, grant next.
        entry_req = 1'b1; exit_req = 1'b1; exit_spot = 3'd2;
        sb.push_back(ex(0, 5, 1, 0, 0, 8'hFB));
        cyc();
        exit_req = 1'b0;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL same_cycle_deny: got %b want %b", obs, e);
        end
        sb.push_back(ex(1, 2, 0, 0, 1, 8'hFF));
        cyc();
        entry_req = 1'b0;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL same_cycle_grant: got %b want %b", obs, e);
        end
        for (int i = 0; i < 3; i++) sb.push_back(ex(0, 2, 0, 0, 1, 8'hFF));
        sb.push_back(ex(0, 2, 0, 0, 0, 8'hFF));
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL same_cycle_gate: got %b want %b", obs, e);
            end
        end
    endtask

    task automatic test_exit_err();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        entry_req = 1'b1;
        sb.push_back(ex(1, 0, 0, 0, 1, 8'h01));
        for (int i = 0; i < 3; i++) sb.push_back(ex(0, 0, 0, 0, 1, 8'h01));
        sb.push_back(ex(0, 0, 0, 0, 0, 8'h01));
        sb.push_back(ex(1, 1, 0, 0, 1, 8'h03));
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL err_setup: got %b want %b", obs, e);
            end
        end
        entry_req = 1'b0; exit_req = 1'b1; exit_spot = 3'd6;
        sb.push_back(ex(0, 1, 0, 1, 1, 8'h03));
        cyc();
        exit_req = 1'b0;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL exit_err: got %b want %b", obs, e);
        end
        sb.push_back(ex(0, 1, 0, 0, 1, 8'h03));
        sb.push_back(ex(0, 1, 0, 0, 1, 8'h03));
        sb.push_back(ex(0, 1, 0, 0, 0, 8'h03));
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL exit_err_after: got %b want %b", obs, e);
            end
        end
    endtask

    task automatic test_reset_open();
        entry_req = 1'b1;
        sb.push_back(ex(1, 2, 0, 0, 1, 8'h07));
        sb.push_back(ex(0, 2, 0, 0, 1, 8'h07));
        cyc();
        entry_req = 1'b0;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL ro_grant: got %b want %b", obs, e);
        end
        cyc();
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL ro_gate2: got %b want %b", obs, e);
        end
        rst = 1'b1;
        sb.push_back(ex(0, 0, 0, 0, 0, 8'h00));
        cyc();
        rst = 1'b0;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL ro_reset: got %b want %b", obs, e);
        end
        // Back in IDLE: a new request is granted on the very next edge.
        entry_req = 1'b1;
        sb.push_back(ex(1, 0, 0, 0, 1, 8'h01));
        cyc();
        entry_req = 1'b0;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL ro_idle_grant: got %b want %b", obs, e);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; exit_spot = 3'd0;
        test_reset();
        test_single_grant();
        test_fill();
        test_exit_refill();
        test_back_to_back();
        test_exit_err();
        test_reset_open();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
